puf_majority_sampler: RTL
=========================

Name: puf_majority_sampler

Overview:
- Upstream conditioning stage for the fuzzy extractor's PUF interface.
- On each puf_read_req, reads the raw PUF array NUM_SAMPLES times, one 32-bit word per raw read.
- Majority-votes every bit and returns a stabilized PUF_BLOCKS*32-bit response on puf_data/puf_valid.
- Also reports which bits were unstable, for enrollment quality monitoring.

Parameters:
- PUF_BLOCKS, 2, number of 32-bit PUF words per response; must be >= 1.
- NUM_SAMPLES, 7, reads per bit; must be odd and >= 3.
- TIMEOUT, 64, max cycles in S_WAIT for raw_valid before abort; must be >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- puf_read_req  in  1  request pulse from fuzzy extractor
- puf_data  out  PUF_BLOCKS*32  majority-voted response
- puf_valid  out  1  one-cycle pulse; puf_data valid
- raw_req  out  1  one-cycle read strobe to raw PUF array
- raw_addr  out  $clog2(PUF_BLOCKS) (min 1)  word index being read
- raw_data  in  32  raw PUF word
- raw_valid  in  1  raw_data valid; honoured only in S_WAIT
- unstable_mask  out  PUF_BLOCKS*32  bit=1 if votes not unanimous
- unstable_count  out  $clog2(PUF_BLOCKS*32+1)  popcount of unstable_mask
- puf_error  out  1  one-cycle pulse on raw timeout
- busy  out  1  high in every state except S_IDLE

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: all outputs 0, state S_IDLE, all vote counters 0, sample counter 0, block counter 0.
- Per-bit vote counters: PUF_BLOCKS*32 counters, CNT_W = $clog2(NUM_SAMPLES+1) bits each; they never overflow.
- S_IDLE:
  - puf_read_req=1: clear vote counters, clear sample and block counters, go to S_REQ.
  - Otherwise stay. raw_valid is ignored.
- S_REQ:
  - raw_req=1 and raw_addr=block counter for exactly this cycle.
  - Clear timer, go to S_WAIT.
- S_WAIT:
  - On raw_valid: counter[blk*32+i] += raw_data[i] for i in 0..31.
  - If blk is the last block: blk=0 and sample++. Go to S_FINAL if that was sample NUM_SAMPLES-1, else to S_REQ.
  - If blk is not the last block: blk++, go to S_REQ.
  - If raw_valid is absent: timer++. When timer reaches TIMEOUT-1 with no raw_valid, pulse puf_error and go to S_IDLE. puf_valid is not asserted; puf_data and the mask keep their previous values.
- S_FINAL, registering outputs:
  - puf_data bit = (count >= (NUM_SAMPLES+1)/2).
  - unstable_mask bit = (count != 0 && count != NUM_SAMPLES).
  - unstable_count = popcount(unstable_mask).
  - Go to S_OUT.
- S_OUT: puf_valid=1 for one cycle, then S_IDLE. Outputs hold until the next S_FINAL or reset.
- puf_read_req while busy is ignored. It is not queued.
- raw_valid outside S_WAIT is ignored, including stale responses after a timeout.
- Reset in any state returns to S_IDLE within the same edge. No puf_valid or puf_error follows the reset.
- Latency:
  - W = NUM_SAMPLES*PUF_BLOCKS words; L = cycles from raw_req to raw_valid (L >= 1).
  - puf_valid is asserted 2 + W*(L+1) cycles after the cycle puf_read_req is sampled.
  - Defaults with L=1: 30 cycles.

Decomposition:
- Shared package puf_pkg holds:
  - state encoding: S_IDLE, S_REQ, S_WAIT, S_FINAL, S_OUT;
  - CNT_W and MAJ_THRESH = (NUM_SAMPLES+1)/2, as functions of the parameters;
  - a popcount function.
- One sub-module, puf_vote_counter, instantiated once per bit via generate:
  - inputs: clr, inc_en, bit_in;
  - outputs: count, majority, unstable.
- Top level holds the FSM, the timer and the sample/block counters.

Test Plan:
- Stable PUF: raw model returns 32'hA5A5_0F0F for addr 0 and 32'h1234_5678 for addr 1, L=1, one puf_read_req.
  Required: puf_valid at cycle 30; puf_data = 64'h1234_5678_A5A5_0F0F; unstable_mask = 0; unstable_count = 0; exactly 14 raw_req pulses with raw_addr alternating 0,1.
- Noisy bit 0 of word 0 reads 1 in 4 of 7 samples; otherwise as above.
  Required: puf_data[0] = 1, unstable_mask[0] = 1, unstable_count = 1.
- Same noisy bit, 3 of 7 samples reads 1.
  Required: puf_data[0] = 0, unstable_mask[0] = 1.
- Raw model stops responding after the 5th raw_req.
  Required: puf_error pulses exactly once, TIMEOUT cycles after that raw_req; puf_valid stays 0; busy=0 on the next cycle; a late raw_valid is ignored; a subsequent request completes normally.
- Reset asserted mid-S_WAIT of sample 3.
  Required: busy=0 and all outputs 0 on the next cycle; a new request yields a correct result with no residue from the previous counts.
- puf_read_req pulsed again while busy; raw latency L=3.
  Required: no second acquisition; puf_valid at 2 + 14*4 = 58 cycles after the first request.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and helpers for the PUF majority sampler.
// State encoding, vote-counter sizing, majority threshold, popcount.
package puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FINAL,
    S_OUT
  } state_e;

  // Width that holds 0..ns votes.
  function automatic int cnt_w(int ns);
    return $clog2(ns + 1);
  endfunction

  function automatic int maj_thresh(int ns);
    return (ns + 1) / 2;
  endfunction

  function automatic logic [5:0] popcount32(
    logic [31:0] v
  );
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < 32; i++)
      s = s + {5'd0, v[i]};
    return s;
  endfunction

endpackage

// File: rtl/puf_vote_counter.sv
// Per-bit vote counter: counts raw reads that returned 1.
// Ports: clk, reset, clr, inc_en, bit_in -> count, majority, unstable.
module puf_vote_counter
  import puf_pkg::*;
#(
  parameter int NUM_SAMPLES = 7,
  parameter int CNT_W = cnt_w(NUM_SAMPLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc_en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count,
  output logic             majority,
  output logic             unstable
);

  localparam logic [CNT_W-1:0] THR =
    CNT_W'(maj_thresh(NUM_SAMPLES));
  localparam logic [CNT_W-1:0] ALL =
    CNT_W'(NUM_SAMPLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc_en && bit_in)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign count    = cnt_q;
  assign majority = (cnt_q >= THR);
  assign unstable = (cnt_q != '0) &&
                    (cnt_q != ALL);

endmodule

// File: rtl/puf_majority_sampler.sv
// Reads the raw PUF NUM_SAMPLES times per block and majority-votes bits.
// Ports: puf_read_req -> raw_req/raw_addr/raw_data/raw_valid -> puf_data.
module puf_majority_sampler
  import puf_pkg::*;
#(
  parameter int PUF_BLOCKS  = 2,
  parameter int NUM_SAMPLES = 7,
  parameter int TIMEOUT     = 64,
  localparam int NB = PUF_BLOCKS * 32,
  localparam int AW =
    (PUF_BLOCKS > 1) ? $clog2(PUF_BLOCKS) : 1,
  localparam int UW = $clog2(NB + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          puf_read_req,
  output logic [NB-1:0] puf_data,
  output logic          puf_valid,
  output logic          raw_req,
  output logic [AW-1:0] raw_addr,
  input  logic [31:0]   raw_data,
  input  logic          raw_valid,
  output logic [NB-1:0] unstable_mask,
  output logic [UW-1:0] unstable_count,
  output logic          puf_error,
  output logic          busy
);

  localparam int CW = cnt_w(NUM_SAMPLES);
  localparam int SW = $clog2(NUM_SAMPLES);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [AW-1:0] LAST_BLK =
    AW'(PUF_BLOCKS - 1);
  localparam logic [SW-1:0] LAST_SMP =
    SW'(NUM_SAMPLES - 1);
  // Abort fires when the timer would reach TIMEOUT-1.
  localparam logic [TW-1:0] TMR_END =
    TW'(TIMEOUT - 2);

  state_e          state_q;
  logic [SW-1:0]   smp_q;
  logic [AW-1:0]   blk_q;
  logic [TW-1:0]   tmr_q;
  logic            valid_q;
  logic            error_q;
  logic [NB-1:0]   data_q;
  logic [NB-1:0]   mask_q;
  logic [UW-1:0]   ucnt_q;
  logic [UW-1:0]   ucnt_d;

  logic                  clr;
  logic                  take;
  logic [PUF_BLOCKS-1:0] inc_v;
  logic [NB-1:0]         maj_v;
  logic [NB-1:0]         uns_v;
  logic [CW-1:0]         unused_cnt [NB];

  assign clr  = (state_q == S_IDLE) &&
                puf_read_req;
  assign take = (state_q == S_WAIT) &&
                raw_valid;

  for (genvar b = 0; b < PUF_BLOCKS; b++)
  begin : g_inc
    assign inc_v[b] = take &&
                      (blk_q == AW'(b));
  end

  for (genvar g = 0; g < NB; g++)
  begin : g_vote
    puf_vote_counter #(
      .NUM_SAMPLES(NUM_SAMPLES),
      .CNT_W      (CW)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .inc_en  (inc_v[g/32]),
      .bit_in  (raw_data[g%32]),
      .count   (unused_cnt[g]),
      .majority(maj_v[g]),
      .unstable(uns_v[g])
    );
  end

  always_comb begin
    ucnt_d = '0;
    for (int b = 0; b < PUF_BLOCKS; b++)
      ucnt_d = ucnt_d +
        UW'(popcount32(uns_v[b*32 +: 32]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      smp_q   <= '0;
      blk_q   <= '0;
      tmr_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      ucnt_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (puf_read_req) begin
            smp_q   <= '0;
            blk_q   <= '0;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          tmr_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (raw_valid) begin
            if (blk_q == LAST_BLK) begin
              blk_q <= '0;
              if (smp_q == LAST_SMP) begin
                state_q <= S_FINAL;
              end else begin
                smp_q   <= smp_q + 1'b1;
                state_q <= S_REQ;
              end
            end else begin
              blk_q   <= blk_q + 1'b1;
              state_q <= S_REQ;
            end
          end else if (tmr_q == TMR_END) begin
            error_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_FINAL: begin
          data_q  <= maj_v;
          mask_q  <= uns_v;
          ucnt_q  <= ucnt_d;
          valid_q <= 1'b1;
          state_q <= S_OUT;
        end
        S_OUT: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign raw_req        = (state_q == S_REQ);
  assign raw_addr       = blk_q;
  assign busy           = (state_q != S_IDLE);
  assign puf_valid      = valid_q;
  assign puf_error      = error_q;
  assign puf_data       = data_q;
  assign unstable_mask  = mask_q;
  assign unstable_count = ucnt_q;

endmodule
